// File: rtl/controlador_varredura.sv
// ============================================================================
// controlador_varredura
// ----------------------------------------------------------------------------
// Sweep controller for an external polynomial evaluator. After a request it
// walks X from X_ini to X_fim (inclusive, unsigned). For each point it:
//    - fires a one-cycle start strobe (inicio) with X held stable,
//    - waits for the evaluator's done flag (pronto),
//    - records the result.
// While sweeping it keeps the largest non-overflow result, the X that produced
// it, and a saturating count of evaluations that reported overflow.
//
// Optional feature (compile-time macro):
//    TIMEOUT_EN  - when defined, a watchdog counts cycles spent waiting for
//                  pronto. If it reaches TIMEOUT_CICLOS, the sweep is aborted
//                  and erro_timeout is raised. Results captured so far are
//                  kept. When undefined the wait is unbounded and
//                  erro_timeout is always 0.
//
// Parameters:
//    LARGURA         width of X, Resultado and all result registers
//    TIMEOUT_CICLOS  watchdog limit in cycles (only used with TIMEOUT_EN)
//
// Ports:
//    ck            clock, everything changes on its rising edge
//    rst           synchronous active-high reset
//    iniciar       sweep request, only looked at while idle
//    X_ini, X_fim  inclusive sweep bounds, sampled together with iniciar
//    inicio        start strobe to the evaluator
//    X             operand to the evaluator
//    Resultado     evaluator result
//    pronto        evaluator done flag
//    overflow      evaluator overflow flag, valid together with pronto
//    ocupado       sweep in progress
//    concluido     one-cycle pulse when the sweep ends
//    max_res       largest non-overflow result of the sweep
//    X_max         X that produced max_res
//    max_valido    at least one non-overflow result was captured
//    qtd_overflow  number of overflowed evaluations, saturating
//    erro_faixa    sticky: request had X_ini > X_fim
//    erro_timeout  sticky: evaluator did not answer in time
// ============================================================================
module controlador_varredura #(
   parameter int LARGURA        = 16,
   parameter int TIMEOUT_CICLOS = 64
) (
   input  logic               ck,
   input  logic               rst,
   input  logic               iniciar,
   input  logic [LARGURA-1:0] X_ini,
   input  logic [LARGURA-1:0] X_fim,
   output logic               inicio,
   output logic [LARGURA-1:0] X,
   input  logic [LARGURA-1:0] Resultado,
   input  logic               pronto,
   input  logic               overflow,
   output logic               ocupado,
   output logic               concluido,
   output logic [LARGURA-1:0] max_res,
   output logic [LARGURA-1:0] X_max,
   output logic               max_valido,
   output logic [LARGURA-1:0] qtd_overflow,
   output logic               erro_faixa,
   output logic               erro_timeout
);

   // Sweep sequencing states:
   //    OCIOSO  - idle, waiting for a request
   //    DISPARA - strobe inicio for the current X
   //    ESPERA  - hold X until the evaluator reports done
   //    LIBERA  - wait for pronto to drop before moving on
   //    FIM     - one-cycle end-of-sweep pulse
   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      DISPARA = 3'd1,
      ESPERA  = 3'd2,
      LIBERA  = 3'd3,
      FIM     = 3'd4
   } estado_t;

   estado_t estadoAtual;
   estado_t proxEstado;

   logic [LARGURA-1:0] xReg;
   logic [LARGURA-1:0] xFimReg;
   logic [LARGURA-1:0] maxResReg;
   logic [LARGURA-1:0] xMaxReg;
   logic [LARGURA-1:0] qtdOverflowReg;
   logic               maxValidoReg;
   logic               erroFaixaReg;
   logic               erroTimeoutReg;

   logic faixaOk;
   logic ultimoPonto;
   logic novoMaximo;
   logic timeoutAtingido;

   // A request is only honoured when the bounds describe a non-empty range.
   assign faixaOk = (X_ini <= X_fim);

   // The end test looks at the current X before any increment. This lets a
   // sweep ending at all-ones finish without wrapping back to zero.
   assign ultimoPonto = (xReg == xFimReg);

   // Strictly greater keeps the earliest X on ties. The sweep only ascends,
   // so the earliest X is also the smallest X.
   assign novoMaximo = !maxValidoReg || (Resultado > maxResReg);

`ifdef TIMEOUT_EN
   localparam int ContW = $clog2(TIMEOUT_CICLOS + 1);

   logic [ContW-1:0] contEspera;

   // Watchdog: counts the cycles spent in ESPERA without a done flag. It
   // restarts from zero every time the FSM enters ESPERA for a new point.
   always_ff @(posedge ck) begin
      if (rst) begin
         contEspera <= '0;
      end else if (estadoAtual != ESPERA) begin
         contEspera <= '0;
      end else if (!pronto) begin
         contEspera <= contEspera + 1'b1;
      end
   end

   // Fires during the last allowed cycle of waiting. This way FIM is entered
   // exactly TIMEOUT_CICLOS cycles after ESPERA was entered.
   assign timeoutAtingido = (estadoAtual == ESPERA) && !pronto &&
                            (contEspera == ContW'(TIMEOUT_CICLOS - 1));
`else
   logic unusedTimeoutCiclos;

   assign timeoutAtingido     = 1'b0;
   assign unusedTimeoutCiclos = (TIMEOUT_CICLOS == 0);
`endif

   // State register.
   always_ff @(posedge ck) begin
      if (rst) begin
         estadoAtual <= OCIOSO;
      end else begin
         estadoAtual <= proxEstado;
      end
   end

   // Next-state and strobe outputs. The strobes decode the state directly.
   // A reset therefore removes them at the very edge that applies it.
   always_comb begin
      proxEstado = estadoAtual;
      inicio     = 1'b0;
      ocupado    = 1'b0;
      concluido  = 1'b0;
      unique case (estadoAtual)
         OCIOSO: begin
            if (iniciar) begin
               proxEstado = faixaOk ? DISPARA : FIM;
            end
         end
         DISPARA: begin
            inicio     = 1'b1;
            ocupado    = 1'b1;
            proxEstado = ESPERA;
         end
         ESPERA: begin
            ocupado = 1'b1;
            if (pronto) begin
               proxEstado = LIBERA;
            end else if (timeoutAtingido) begin
               proxEstado = FIM;
            end
         end
         LIBERA: begin
            ocupado = 1'b1;
            if (!pronto) begin
               proxEstado = ultimoPonto ? FIM : DISPARA;
            end
         end
         FIM: begin
            concluido  = 1'b1;
            proxEstado = OCIOSO;
         end
         default: begin
            proxEstado = OCIOSO;
         end
      endcase
   end

   // Datapath: sweep position and result registers.
   //
   // Any request seen while idle clears the result registers and both sticky
   // errors. This includes a request with a bad range, which then sets
   // erro_faixa. Results are captured only on the first cycle of pronto in
   // ESPERA. LIBERA swallows the rest of a longer done pulse.
   always_ff @(posedge ck) begin
      if (rst) begin
         xReg           <= '0;
         xFimReg        <= '0;
         maxResReg      <= '0;
         xMaxReg        <= '0;
         qtdOverflowReg <= '0;
         maxValidoReg   <= 1'b0;
         erroFaixaReg   <= 1'b0;
         erroTimeoutReg <= 1'b0;
      end else begin
         unique case (estadoAtual)
            OCIOSO: begin
               if (iniciar) begin
                  maxResReg      <= '0;
                  xMaxReg        <= '0;
                  qtdOverflowReg <= '0;
                  maxValidoReg   <= 1'b0;
                  erroTimeoutReg <= 1'b0;
                  if (faixaOk) begin
                     xReg         <= X_ini;
                     xFimReg      <= X_fim;
                     erroFaixaReg <= 1'b0;
                  end else begin
                     erroFaixaReg <= 1'b1;
                  end
               end
            end
            ESPERA: begin
               if (pronto) begin
                  if (overflow) begin
                     if (qtdOverflowReg != '1) begin
                        qtdOverflowReg <= qtdOverflowReg + 1'b1;
                     end
                  end else if (novoMaximo) begin
                     maxResReg    <= Resultado;
                     xMaxReg      <= xReg;
                     maxValidoReg <= 1'b1;
                  end
               end else if (timeoutAtingido) begin
                  erroTimeoutReg <= 1'b1;
               end
            end
            LIBERA: begin
               if (!pronto && !ultimoPonto) begin
                  xReg <= xReg + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign X            = xReg;
   assign max_res      = maxResReg;
   assign X_max        = xMaxReg;
   assign max_valido   = maxValidoReg;
   assign qtd_overflow = qtdOverflowReg;
   assign erro_faixa   = erroFaixaReg;

`ifdef TIMEOUT_EN
   assign erro_timeout = erroTimeoutReg;
`else
   logic unusedErroTimeout;

   assign erro_timeout      = 1'b0;
   assign unusedErroTimeout = erroTimeoutReg;
`endif

endmodule

// File: tb/tb_controlador_varredura.sv
// ============================================================================
// tb_controlador_varredura
// ----------------------------------------------------------------------------
// Bench for controlador_varredura. It contains a behavioural evaluator:
//    - 3-cycle latency,
//    - Resultado = 3*X+1 truncated to 16 bits,
//    - one-cycle pronto pulse.
// It also contains a reference model that works out the expected results of a
// sweep directly from the bounds with plain integer arithmetic.
// ============================================================================
module tb_controlador_varredura;

   localparam int LARGURA = 16;

   logic               ck;
   logic               rst;
   logic               iniciar;
   logic [LARGURA-1:0] X_ini;
   logic [LARGURA-1:0] X_fim;
   logic               inicio;
   logic [LARGURA-1:0] X;
   logic [LARGURA-1:0] Resultado;
   logic               pronto;
   logic               overflow;
   logic               ocupado;
   logic               concluido;
   logic [LARGURA-1:0] max_res;
   logic [LARGURA-1:0] X_max;
   logic               max_valido;
   logic [LARGURA-1:0] qtd_overflow;
   logic               erro_faixa;
   logic               erro_timeout;

   int nAssercoes = 0;
   int nFalhas    = 0;

   // Evaluator behaviour knobs:
   //    modoOvf   0 = never overflow
   //              1 = overflow only at ovfX
   //              2 = pseudo-random pattern
   //              3 = always overflow
   //    semPronto never answers
   int          modoOvf    = 0;
   logic [15:0] ovfX       = '0;
   logic [15:0] sementeOvf = '0;
   bit          semPronto  = 0;

   // Monitor records
   logic [15:0] inicioXs[$];
   int          nConcluido = 0;

   // Reference model results
   int          expN;
   logic [15:0] expMax;
   logic [15:0] expXMax;
   logic        expValido;
   logic [15:0] expQtd;

   controlador_varredura #(
      .LARGURA(LARGURA),
      .TIMEOUT_CICLOS(64)
   ) dut (
      .ck          (ck),
      .rst         (rst),
      .iniciar     (iniciar),
      .X_ini       (X_ini),
      .X_fim       (X_fim),
      .inicio      (inicio),
      .X           (X),
      .Resultado   (Resultado),
      .pronto      (pronto),
      .overflow    (overflow),
      .ocupado     (ocupado),
      .concluido   (concluido),
      .max_res     (max_res),
      .X_max       (X_max),
      .max_valido  (max_valido),
      .qtd_overflow(qtd_overflow),
      .erro_faixa  (erro_faixa),
      .erro_timeout(erro_timeout)
   );

   // Free-running clock.
   initial begin
      ck = 1'b0;
      forever #5 ck = ~ck;
   end

   // Which points the evaluator flags as overflowing.
   function automatic logic ovfDe(input int x);
      logic [15:0] xv;
      xv = x[15:0];
      case (modoOvf)
         1:       return (xv == ovfX);
         2:       return (((xv ^ sementeOvf) % 16'd3) == 16'd0);
         3:       return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [15:0] resultadoDe(input int x);
      int r;
      r = (3 * x + 1) % 65536;
      return r[15:0];
   endfunction

   // Evaluator model plus output monitor. Both run on the falling edge, away
   // from the edge where the DUT samples.
   initial begin : avaliador
      int          contaLat;
      logic [15:0] xEmAval;
      contaLat  = 0;
      xEmAval   = '0;
      pronto    = 1'b0;
      overflow  = 1'b0;
      Resultado = '0;
      forever begin
         @(negedge ck);
         pronto   = 1'b0;
         overflow = 1'b0;
         if (inicio) begin
            inicioXs.push_back(X);
            xEmAval  = X;
            contaLat = 3;
         end else if (contaLat > 0) begin
            contaLat--;
            if (contaLat == 0 && !semPronto) begin
               pronto    = 1'b1;
               Resultado = resultadoDe(int'(xEmAval));
               overflow  = ovfDe(int'(xEmAval));
            end
         end
         if (concluido) nConcluido++;
         if (rst) contaLat = 0;
      end
   end

   // One comparison: counted, asserted, reported on failure.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      nAssercoes++;
      assert (obs === exp)
      else begin
         nFalhas++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected outcome of a sweep.
   // Pass 1 finds the best non-overflow value. Pass 2 finds the first
   // (smallest) X that produced it.
   task automatic calcModelo(input int xi, input int xf);
      int  melhor;
      bit  achou;
      expN      = xf - xi + 1;
      expQtd    = '0;
      expValido = 1'b0;
      expMax    = '0;
      expXMax   = '0;
      melhor    = -1;
      achou     = 0;
      for (int x = xi; x <= xf; x++) begin
         if (ovfDe(x)) expQtd++;
         else if (int'(resultadoDe(x)) > melhor) melhor = int'(resultadoDe(x));
      end
      for (int x = xi; x <= xf; x++) begin
         if (!achou && !ovfDe(x) && int'(resultadoDe(x)) == melhor) begin
            achou     = 1;
            expValido = 1'b1;
            expMax    = melhor[15:0];
            expXMax   = x[15:0];
         end
      end
   endtask

   task automatic checkZerado(input string tag);
      checkOutput({tag, "_inicio"}, inicio, 0);
      checkOutput({tag, "_X"}, X, 0);
      checkOutput({tag, "_ocupado"}, ocupado, 0);
      checkOutput({tag, "_concluido"}, concluido, 0);
      checkOutput({tag, "_max_res"}, max_res, 0);
      checkOutput({tag, "_X_max"}, X_max, 0);
      checkOutput({tag, "_max_valido"}, max_valido, 0);
      checkOutput({tag, "_qtd_overflow"}, qtd_overflow, 0);
      checkOutput({tag, "_erro_faixa"}, erro_faixa, 0);
      checkOutput({tag, "_erro_timeout"}, erro_timeout, 0);
   endtask

   // Request a sweep. Called just after a rising edge. Returns just after
   // the edge that sampled iniciar.
   task automatic iniciaVarredura(input int xi, input int xf);
      inicioXs.delete();
      nConcluido = 0;
      X_ini      = xi[15:0];
      X_fim      = xf[15:0];
      iniciar    = 1'b1;
      @(posedge ck);
      #1;
      iniciar = 1'b0;
   endtask

   // Full sweep with checks against the reference model.
   // A stray request is injected mid-sweep; it must be ignored.
   task automatic applyStimulus(input string tag, input int xi, input int xf);
      int ciclos;
      int limite;
      calcModelo(xi, xf);
      iniciaVarredura(xi, xf);
      checkOutput({tag, "_inicio_1o"}, inicio, 1);
      checkOutput({tag, "_ocupado_1o"}, ocupado, 1);
      checkOutput({tag, "_X_1o"}, X, xi[15:0]);
      limite = expN * 5 + 20;
      ciclos = 0;
      while (nConcluido == 0 && ciclos < limite) begin
         @(posedge ck);
         #1;
         ciclos++;
         if (ciclos == 2) begin
            X_ini   = 16'd0;
            X_fim   = 16'd0;
            iniciar = 1'b1;
         end else begin
            iniciar = 1'b0;
         end
      end
      iniciar = 1'b0;
      if (nConcluido == 0) checkOutput({tag, "_prazo_concluido"}, 0, 1);
      repeat (3) @(posedge ck);
      #1;
      checkOutput({tag, "_n_inicio"}, inicioXs.size(), expN);
      for (int i = 0; i < inicioXs.size() && i < expN; i++) begin
         checkOutput({tag, "_X_seq"}, inicioXs[i], 32'(xi + i) & 32'hFFFF);
      end
      checkOutput({tag, "_n_concluido"}, nConcluido, 1);
      checkOutput({tag, "_max_res"}, max_res, expMax);
      checkOutput({tag, "_X_max"}, X_max, expXMax);
      checkOutput({tag, "_max_valido"}, max_valido, expValido);
      checkOutput({tag, "_qtd_overflow"}, qtd_overflow, expQtd);
      checkOutput({tag, "_erro_faixa"}, erro_faixa, 0);
      checkOutput({tag, "_erro_timeout"}, erro_timeout, 0);
      checkOutput({tag, "_ocupado_fim"}, ocupado, 0);
   endtask

   initial begin : principal
      int ciclos;
      int comp;
      int xi;
      rst     = 1'b1;
      iniciar = 1'b0;
      X_ini   = '0;
      X_fim   = '0;

      // Reset state
      repeat (3) @(posedge ck);
      #1;
      checkZerado("reset");
      rst = 1'b0;
      @(posedge ck);
      #1;

      // Basic sweep 5..7
      modoOvf = 0;
      applyStimulus("varre_5_7", 5, 7);
      checkOutput("ref_5_7_max", max_res, 22);
      checkOutput("ref_5_7_xmax", X_max, 7);

      // Overflow reported at X=7
      modoOvf = 1;
      ovfX    = 16'd7;
      applyStimulus("ovf_em_7", 5, 7);
      checkOutput("ref_ovf_max", max_res, 19);
      checkOutput("ref_ovf_xmax", X_max, 6);
      checkOutput("ref_ovf_qtd", qtd_overflow, 1);
      modoOvf = 0;

      // Inverted range: no evaluation, immediate end with erro_faixa
      iniciaVarredura(10, 9);
      checkOutput("faixa_concluido", concluido, 1);
      checkOutput("faixa_erro", erro_faixa, 1);
      checkOutput("faixa_inicio", inicio, 0);
      @(posedge ck);
      #1;
      checkOutput("faixa_concluido_fim", concluido, 0);
      repeat (4) @(posedge ck);
      #1;
      checkOutput("faixa_n_inicio", inicioXs.size(), 0);
      checkOutput("faixa_n_concluido", nConcluido, 1);
      checkOutput("faixa_erro_sticky", erro_faixa, 1);

      // Single point at all-ones: result truncates, no wrap afterwards
      applyStimulus("ponto_ffff", 65535, 65535);
      checkOutput("ref_ffff_max", max_res, 16'hFFFE);

      // End of range without wrap, and non-monotonic truncated results
      applyStimulus("fim_ffff", 65530, 65535);
      applyStimulus("trunc_5555", 16'h5553, 16'h5557);
      checkOutput("ref_5555_xmax", X_max, 16'h5554);

      // All points overflow: no maximum captured
      modoOvf = 3;
      applyStimulus("tudo_ovf", 100, 103);
      modoOvf = 0;

      // Reset while waiting at X=6
      iniciaVarredura(5, 7);
      ciclos = 0;
      while (!(inicio && X == 16'd6) && ciclos < 40) begin
         @(posedge ck);
         #1;
         ciclos++;
      end
      checkOutput("rst_alcanca_x6", (inicio && X == 16'd6), 1);
      @(posedge ck);
      #1;
      checkOutput("rst_espera_ocupado", ocupado, 1);
      checkOutput("rst_max_antes", max_res, 16);
      rst = 1'b1;
      @(posedge ck);
      #1;
      rst = 1'b0;
      checkZerado("rst_meio");
      repeat (10) @(posedge ck);
      #1;
      checkOutput("rst_sem_concluido", nConcluido, 0);
      applyStimulus("apos_rst", 5, 7);

      // Randomized sweeps with a pseudo-random overflow pattern
      modoOvf = 2;
      for (int k = 0; k < 6; k++) begin
         comp       = int'($urandom_range(0, 10));
         xi         = int'($urandom_range(0, 65535 - comp));
         sementeOvf = 16'($urandom);
         applyStimulus("aleatorio", xi, xi + comp);
      end
      modoOvf = 0;

`ifdef TIMEOUT_EN
      // Evaluator never answers: watchdog ends the sweep 64 cycles after
      // entering the wait state.
      semPronto = 1;
      iniciaVarredura(5, 7);
      @(posedge ck);
      #1;
      ciclos = 0;
      while (!concluido && ciclos < 200) begin
         @(posedge ck);
         #1;
         ciclos++;
      end
      checkOutput("timeout_ciclos", ciclos, 64);
      checkOutput("timeout_erro", erro_timeout, 1);
      checkOutput("timeout_n_inicio", inicioXs.size(), 1);
      semPronto = 0;
      @(posedge ck);
      #1;
      applyStimulus("apos_timeout", 5, 7);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               nAssercoes, nFalhas);
      $finish;
   end

endmodule
